// File: rtl/avalon_arbiter_2m.sv
// Two-master Avalon-MM burst arbiter sharing one slave; the owner's command is forwarded combinationally.
// Define ARB_FIXED_PRIORITY_EN for fixed m0 priority on ties; default build is round-robin.
module avalon_arbiter_2m #(
    parameter int DATA_BYTES   = 4,
    parameter int BURSTCOUNT_W = 6,
    parameter int ADDR_W       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         m0_address,
    input  logic [DATA_BYTES-1:0]     m0_byteenable,
    input  logic                      m0_read,
    input  logic                      m0_write,
    input  logic [8*DATA_BYTES-1:0]   m0_writedata,
    input  logic [BURSTCOUNT_W-1:0]   m0_burstcount,
    output logic [8*DATA_BYTES-1:0]   m0_readdata,
    output logic                      m0_readdatavalid,
    output logic                      m0_waitrequest,
    input  logic [ADDR_W-1:0]         m1_address,
    input  logic [DATA_BYTES-1:0]     m1_byteenable,
    input  logic                      m1_read,
    input  logic                      m1_write,
    input  logic [8*DATA_BYTES-1:0]   m1_writedata,
    input  logic [BURSTCOUNT_W-1:0]   m1_burstcount,
    output logic [8*DATA_BYTES-1:0]   m1_readdata,
    output logic                      m1_readdatavalid,
    output logic                      m1_waitrequest,
    output logic [ADDR_W-1:0]         s_address,
    output logic [DATA_BYTES-1:0]     s_byteenable,
    output logic                      s_read,
    output logic                      s_write,
    output logic [8*DATA_BYTES-1:0]   s_writedata,
    output logic [BURSTCOUNT_W-1:0]   s_burstcount,
    input  logic [8*DATA_BYTES-1:0]   s_readdata,
    input  logic                      s_readdatavalid,
    input  logic                      s_waitrequest
);
    typedef enum logic [1:0] {IDLE, ARB, WR_BURST, RD_WAIT} state_t;

    state_t                  state;
    logic                    owner;
    logic                    last_served;
    logic                    rd_accepted;
    logic [BURSTCOUNT_W-1:0] burst_len;
    logic [BURSTCOUNT_W-1:0] beat_cnt;

    logic                    req0, req1, grant_sel, sel_write;
    logic [BURSTCOUNT_W-1:0] sel_bc;
    logic                    o_read, o_write, granted, owner_wait;
    logic                    beat_wr, cmd_acc, beat_rd, last_beat;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        if (req0 && req1)
`ifdef ARB_FIXED_PRIORITY_EN
            grant_sel = 1'b0;
`else
            grant_sel = ~last_served;
`endif
        else
            grant_sel = req1 & ~req0;
    end

    assign sel_write = grant_sel ? m1_write : m0_write;
    assign sel_bc    = grant_sel ? m1_burstcount : m0_burstcount;

    assign o_read    = owner ? m1_read  : m0_read;
    assign o_write   = owner ? m1_write : m0_write;

    // Payload always follows the owner; only the strobes are gated by state.
    assign s_address    = owner ? m1_address    : m0_address;
    assign s_byteenable = owner ? m1_byteenable : m0_byteenable;
    assign s_writedata  = owner ? m1_writedata  : m0_writedata;
    assign s_burstcount = burst_len;

    assign granted   = (state == WR_BURST) || (state == RD_WAIT);
    assign s_write   = (state == WR_BURST) && o_write;
    assign s_read    = (state == RD_WAIT) && !rd_accepted && o_read;
    assign owner_wait = ((state == WR_BURST) || ((state == RD_WAIT) && !rd_accepted))
                        ? s_waitrequest : 1'b1;

    assign m0_waitrequest = (granted && !owner) ? owner_wait : 1'b1;
    assign m1_waitrequest = (granted &&  owner) ? owner_wait : 1'b1;

    assign beat_wr   = (state == WR_BURST) && s_write && !s_waitrequest;
    assign cmd_acc   = (state == RD_WAIT) && s_read && !s_waitrequest;
    // Beats arriving outside an accepted read are dropped, never routed.
    assign beat_rd   = (state == RD_WAIT) && rd_accepted && s_readdatavalid;
    assign last_beat = (beat_cnt + BURSTCOUNT_W'(1)) == burst_len;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = beat_rd && !owner;
    assign m1_readdatavalid = beat_rd &&  owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            rd_accepted <= 1'b0;
            burst_len   <= '0;
            beat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) state <= ARB;
                ARB: begin
                    if (req0 || req1) begin
                        owner       <= grant_sel;
                        last_served <= grant_sel;
                        burst_len   <= (sel_bc == '0) ? BURSTCOUNT_W'(1) : sel_bc;
                        beat_cnt    <= '0;
                        rd_accepted <= 1'b0;
                        state       <= sel_write ? WR_BURST : RD_WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WR_BURST: if (beat_wr) begin
                    if (last_beat) begin
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + BURSTCOUNT_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (cmd_acc) rd_accepted <= 1'b1;
                    if (beat_rd) begin
                        if (last_beat) begin
                            beat_cnt    <= '0;
                            rd_accepted <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BURSTCOUNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/avalon_arbiter_2m.md
AVALON_ARBITER_2M -- requirements
Module: avalon_arbiter_2m

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, bytes per data word (data width W = 8*DATA_BYTES).
REQ-002 SHALL have parameter BURSTCOUNT_W, default 6, burstcount width.
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mN_address (N=0,1)  input  ADDR_W  master N address.
REQ-007 mN_byteenable  input  DATA_BYTES  master N byte enables.
REQ-008 mN_read, mN_write  input  1  master N commands.
REQ-009 mN_writedata  input  W  master N write data.
REQ-010 mN_burstcount  input  BURSTCOUNT_W  master N burst length.
REQ-011 mN_readdata  output  W  read data returned to master N.
REQ-012 mN_readdatavalid  output  1  read beat valid for master N.
REQ-013 mN_waitrequest  output  1  stall to master N.
REQ-014 s_address, s_byteenable, s_read, s_write, s_writedata, s_burstcount  output  (widths as master)  command to the shared avalon_bram slave.
REQ-015 s_readdata (input, W), s_readdatavalid (input, 1), s_waitrequest (input, 1)  slave responses.

Function
REQ-016 FSM states: IDLE, ARB, WR_BURST, RD_WAIT.
REQ-017 IDLE: s_read=s_write=0; both mN_waitrequest=1; if any mN_read|mN_write, go to ARB.
REQ-018 ARB: grant owner chosen by round-robin (last-served master lowest priority; first arbitration after reset favours m0); latch owner and burstcount (0 treated as 1); go to WR_BURST if owner's write, else RD_WAIT. Request-to-forward latency: 2 cycles.
REQ-019 While granted, owner's command signals SHALL drive s_* combinationally and s_waitrequest SHALL drive owner's waitrequest; non-owner waitrequest=1.
REQ-020 WR_BURST: beat counter increments on s_write & !s_waitrequest; when count reaches latched burstcount, the owner's waitrequest is forced to 1 from the next cycle and the FSM returns to IDLE.
REQ-021 RD_WAIT: the read command is forwarded until accepted (s_read & !s_waitrequest); afterwards s_read=0 and owner waitrequest=1; each s_readdatavalid increments the beat counter; return to IDLE after the last beat.
REQ-022 mN_readdata SHALL equal s_readdata for both masters; mN_readdatavalid = s_readdatavalid only for the read owner, else 0.
REQ-023 Simultaneous requests from both masters: exactly one is granted; the other holds until the burst completes, and gets served no later than the next grant.
REQ-024 A master deasserting its request before grant SHALL NOT be granted; the grant decision uses requests sampled in the ARB cycle, and if none remain the FSM returns to IDLE.
REQ-025 A read beat that arrives while no read is pending (not in RD_WAIT after acceptance) SHALL NOT be delivered to either master.

Reset
REQ-026 On reset: state=IDLE, beat counter=0, last-served=m1 (so m0 wins the first tie), m0/m1_waitrequest=1, m0/m1_readdatavalid=0, s_read=s_write=0.
REQ-027 Reset asserted mid-burst SHALL abort immediately and produce the values in REQ-026.

Configuration
REQ-028 Macro ARB_FIXED_PRIORITY_EN: defined -> m0 always wins on simultaneous requests (m1 may starve); undefined -> round-robin per REQ-018.

Verification
REQ-029 Single m0 write, burstcount=4, slave waitrequest=0 -> 4 beats reach slave in 4 consecutive cycles, m1_waitrequest stays 1, FSM returns to IDLE.
REQ-030 m0 and m1 read burstcount=2 in the same cycle after reset -> m0 served first (2 readdatavalid on m0 only), then m1 (2 beats on m1 only).
REQ-031 Both masters requesting continuously, 4 bursts each -> grant alternates m0,m1,m0,m1 (undefined macro); with ARB_FIXED_PRIORITY_EN defined -> m0 only.
REQ-032 Slave waitrequest toggling 1,0,1,0 during m1 write burst=3 -> exactly 3 accepted beats, data 0xA0,0xA1,0xA2 arrive in order.
REQ-033 Reset asserted after 2 of 8 read beats -> outputs equal REQ-026 values within the reset cycle; next m1 request is served normally.
REQ-034 m0 write with burstcount=0 -> treated as one beat, FSM returns to IDLE.
